// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection: sequential PC+4 or redirect target, with alignment handling.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (flag misaligned targets instead of masking).
module pc_next_sel
    import rv32_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_pcsrc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_pc_next
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            o_misalign
`endif
);

    // Wraps modulo 2^XLEN; no carry out is reported.
    assign o_pc_plus4 = i_pc + PC_STEP[XLEN-1:0];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign o_pc_next  = i_pcsrc ? i_target : o_pc_plus4;
    assign o_misalign = i_pcsrc && (i_target[1:0] != 2'b00);
`else
    // Low target bits are dropped to force word alignment.
    logic w_unused_tgt_lo;
    assign w_unused_tgt_lo = ^i_target[1:0];
    assign o_pc_next = i_pcsrc ? {i_target[XLEN-1:2], 2'b00} : o_pc_plus4;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, issues word reads over req/ready, holds Instr until acknowledged.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds misalign_trap output and S_HALT).
module instr_fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            instr_ack,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misalign_trap
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] w_pc_next;
    logic            w_pc_load;
    logic            w_instr_load;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            r_trap;
    logic            w_trap_set;
    logic            w_misalign;
`endif

    pc_next_sel #(
        .XLEN       (XLEN)
    ) u_pc_next_sel (
        .i_pc       (r_pc),
        .i_target   (PCTarget),
        .i_pcsrc    (PCSrc),
        .o_pc_plus4 (PCPlus4),
        .o_pc_next  (w_pc_next)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_misalign (w_misalign)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_load    = 1'b0;
        w_instr_load = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        w_trap_set   = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    w_instr_load = 1'b1;
                    w_state_nxt  = S_VALID;
                end
            end
            S_VALID: begin
                if (instr_ack) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = S_FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (w_misalign) begin
                        w_trap_set  = 1'b1;
                        w_state_nxt = S_HALT;
                    end
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            // Only reset leaves the halted state.
            S_HALT:  w_state_nxt = S_HALT;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC[XLEN-1:0];
            r_instr <= NOP_INSTR[XLEN-1:0];
        end else begin
            if (w_pc_load) begin
                r_pc <= w_pc_next;
            end
            if (w_instr_load) begin
                r_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (w_trap_set) begin
            r_trap <= 1'b1;
        end
    end

    assign misalign_trap = r_trap;
`endif

    // Decoded from state so that reset drops the request asynchronously.
    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_VALID);
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign Instr       = r_instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level model plus directed scenarios.
// Honors FETCH_MISALIGN_CHECK_EN to match the DUT build.
module tb_instr_fetch_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        ack;
    logic        ready;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        trap;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    assign rdata = mem_word(addr);

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .XLEN        (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (pcsrc),
        .PCTarget    (tgt),
        .instr_ack   (ack),
        .imem_ready  (ready),
        .imem_rdata  (rdata),
        .imem_req    (req),
        .imem_addr   (addr),
        .Instr       (instr),
        .PC          (pc),
        .PCPlus4     (pc4),
        .instr_valid (valid)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_trap (trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: a pending request, a held instruction, or neither.
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = NOP;
    logic        m_req   = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_start = 1'b1;
    logic        m_halt  = 1'b0;
    logic        m_trap  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_instr <= NOP; m_req <= 1'b0; m_valid <= 1'b0;
            m_start <= 1'b1; m_halt <= 1'b0; m_trap <= 1'b0;
        end else if (m_halt) begin
            m_req <= 1'b0;
        end else if (m_start) begin
            m_start <= 1'b0;
            m_req   <= 1'b1;
        end else if (m_req) begin
            if (ready) begin
                m_instr <= mem_word(m_pc);
                m_req   <= 1'b0;
                m_valid <= 1'b1;
            end
        end else if (m_valid && ack) begin
            m_valid <= 1'b0;
            m_req   <= 1'b1;
            if (!pcsrc) begin
                m_pc <= m_pc + 32'd4;
            end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
                m_pc <= tgt;
                if (tgt[1:0] != 2'b00) begin
                    m_halt <= 1'b1;
                    m_trap <= 1'b1;
                    m_req  <= 1'b0;
                end
`else
                m_pc <= tgt & 32'hFFFF_FFFC;
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("m_req",   {31'b0, req},   {31'b0, m_req});
        chk("m_valid", {31'b0, valid}, {31'b0, m_valid});
        chk("m_pc",    pc,    m_pc);
        chk("m_pc4",   pc4,   m_pc + 32'd4);
        chk("m_instr", instr, m_instr);
        if (m_req) chk("m_addr", addr, m_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("m_trap", {31'b0, trap}, {31'b0, m_trap});
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        ready = 1'b0; ack = 1'b0; pcsrc = 1'b0; tgt = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req",   {31'b0, req},   32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_pc",    pc,    32'h0);
        chk("rst_instr", instr, NOP);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1; ack = 1'b1;

        // Back-to-back fetches, always ready, always acknowledged.
        step(); chk("t1_req0", {31'b0, req}, 32'h1); chk("t1_addr0", addr, 32'h0);
        step(); chk("t1_valid0", {31'b0, valid}, 32'h1); chk("t1_instr0", instr, 32'h5A00_0003);
        step(); chk("t1_addr4", addr, 32'h4);
        step(); chk("t1_instr4", instr, 32'h5A00_0007);
        step(); chk("t1_addr8", addr, 32'h8);
        v = 0;
        repeat (4) begin step(); v += int'(valid); end
        chk("t1_thruput", v, 2);
        ready = 1'b0;

        // Memory stall: request and address held.
        repeat (5) begin
            step();
            chk("t2_req", {31'b0, req}, 32'h1);
            chk("t2_addr", addr, 32'h10);
        end
        ready = 1'b1;
        step(); chk("t2_instr", instr, 32'h5A00_0013);
        ack = 1'b0;

        // Unacknowledged instruction held, then redirected.
        repeat (4) begin
            step();
            chk("t3_valid", {31'b0, valid}, 32'h1);
            chk("t3_pc", pc, 32'h10);
            chk("t3_instr", instr, 32'h5A00_0013);
        end
        pcsrc = 1'b1; tgt = 32'h100; ack = 1'b1;
        step(); chk("t3_addr", addr, 32'h100);
        pcsrc = 1'b0; tgt = 32'h0;
        step(); chk("t3_instr100", instr, 32'h5A00_0103);

        // PC wrap at the top of the address space.
        pcsrc = 1'b1; tgt = 32'hFFFF_FFFC;
        step(); chk("t4_addr_top", addr, 32'hFFFF_FFFC);
        pcsrc = 1'b0; tgt = 32'h0;
        step(); chk("t4_instr_top", instr, 32'hA5FF_FFFF); chk("t4_pc4", pc4, 32'h0);
        step(); chk("t4_addr_wrap", addr, 32'h0); chk("t4_req", {31'b0, req}, 32'h1);

        // Reset during a request with ready asserted.
        rst_n = 1'b0;
        #1;
        chk("t5_req", {31'b0, req}, 32'h0);
        chk("t5_pc", pc, 32'h0);
        chk("t5_instr", instr, NOP);
        @(posedge clk); #1;
        chk("t5_valid", {31'b0, valid}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        step(); chk("t5_refetch", addr, 32'h0);
        step(); chk("t5_valid1", {31'b0, valid}, 32'h1);

        // Misaligned redirect.
        pcsrc = 1'b1; tgt = 32'h102;
        step();
        pcsrc = 1'b0; tgt = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t6_trap", {31'b0, trap}, 32'h1);
        chk("t6_pc", pc, 32'h102);
        repeat (3) begin
            step();
            chk("t6_noreq", {31'b0, req}, 32'h0);
            chk("t6_novalid", {31'b0, valid}, 32'h0);
        end
`else
        chk("t6_req", {31'b0, req}, 32'h1);
        chk("t6_addr", addr, 32'h100);
        step(); chk("t6_instr", instr, 32'h5A00_0103);
`endif
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
